// File: rtl/mips_insmem_pkg.sv
// Shared FSM states, default parameters and line-offset helper for the
// MIPS line-fetch instruction memory.
package mips_insmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_MEM_BYTES  = 1024;
  localparam int DEFAULT_LINE_BYTES = 16;
  localparam int DEFAULT_LATENCY    = 4;

  // log2 of a power-of-two line size: number of byte-offset bits in an address
  function automatic int line_offset(input int line_bytes);
    int ofs;
    ofs = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < line_bytes) ofs = i + 1;
    return ofs;
  endfunction

endpackage

// File: rtl/mips_insmem_wait_counter.sv
// Down-counter timing the WAIT state; done is the terminal-count compare.
module mips_insmem_wait_counter #(
  parameter int WIDTH = 3
) (
  input  logic             ClockPulse,
  input  logic             Reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge ClockPulse) begin
    if (Reset || clear)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/mips_line_fetch_memory.sv
// Read-only line-fetch instruction memory (byte i holds i[7:0]) with fixed miss
// latency. Optional one-entry line buffer enabled by macro INSMEM_LINEBUF_EN.
//
// state | meaning
// IDLE  | ready for a request (unless Flush)
// WAIT  | countdown until the line is available
// RESP  | line presented, held until consumed, flushed or reset
module mips_line_fetch_memory
  import mips_insmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
  parameter int LINE_BYTES = DEFAULT_LINE_BYTES,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                    ClockPulse,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic [ADDR_WIDTH-1:0]   InstructionAddress,
  input  logic                    Flush,
  output logic                    RespValid,
  input  logic                    RespReady,
  output logic [LINE_BYTES*8-1:0] OutputInsMemory,
  output logic [ADDR_WIDTH-1:0]   RespAddress,
  output logic                    AddrError
);

  localparam int OFS = line_offset(LINE_BYTES);
  localparam int LW  = ADDR_WIDTH - OFS;
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [LW-1:0] NUM_LINES  = LW'(MEM_BYTES / LINE_BYTES);
  localparam logic [CW-1:0] MISS_COUNT = CW'(LATENCY - 1);

  state_t                  state, state_next;
  logic [LW-1:0]           req_line, line_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    accept, cnt_load, cnt_done, hit, hit_q, in_range, load_resp;
  logic [CW-1:0]           cnt_value;
  logic [LINE_BYTES*8-1:0] rom_line, buf_data;
  logic                    unused_low_bits;

  assign req_line        = InstructionAddress[ADDR_WIDTH-1:OFS];
  assign unused_low_bits = ^InstructionAddress[OFS-1:0];
  assign base_q          = {line_q, {OFS{1'b0}}};
  assign ReqReady        = (state == IDLE) && !Flush;
  assign accept          = ReqValid && ReqReady;
  assign RespValid       = (state == RESP);
  assign in_range        = (line_q < NUM_LINES);
  // A buffer hit still passes through WAIT, but with a zero count it leaves after one cycle
  assign cnt_value       = hit ? '0 : MISS_COUNT;
  assign load_resp       = (state == WAIT) && (state_next == RESP);

`ifdef INSMEM_LINEBUF_EN
  logic          buf_valid;
  logic [LW-1:0] buf_line;
  logic          consume;

  assign consume = (state == RESP) && RespReady && !Flush;
  assign hit     = buf_valid && (buf_line == req_line);

  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      buf_valid <= 1'b0;
      buf_line  <= '0;
      buf_data  <= '0;
    end else if (consume && !AddrError) begin
      buf_valid <= 1'b1;
      buf_line  <= line_q;
      buf_data  <= OutputInsMemory;
    end
  end
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif

  mips_insmem_wait_counter #(.WIDTH(CW)) u_wait_counter (
    .ClockPulse (ClockPulse),
    .Reset      (Reset),
    .clear      (Flush),
    .load       (cnt_load),
    .load_value (cnt_value),
    .done       (cnt_done)
  );

  // Lines are aligned, so each byte is the base's low byte plus its offset
  always_comb begin
    rom_line = '0;
    for (int k = 0; k < LINE_BYTES; k++)
      rom_line[k*8 +: 8] = base_q[7:0] + 8'(k);
  end

  always_ff @(posedge ClockPulse) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_next = WAIT;
        cnt_load   = 1'b1;
      end
      WAIT: if (Flush)         state_next = IDLE;
            else if (cnt_done) state_next = RESP;
      RESP: if (Flush || RespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      line_q          <= '0;
      hit_q           <= 1'b0;
      OutputInsMemory <= '0;
      RespAddress     <= '0;
      AddrError       <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= req_line;
        hit_q  <= hit;
      end
      if (load_resp) begin
        RespAddress     <= base_q;
        AddrError       <= !in_range;
        OutputInsMemory <= hit_q ? buf_data : (in_range ? rom_line : '0);
      end
    end
  end

endmodule

// File: tb/tb_mips_line_fetch_memory.sv
// Self-checking bench for mips_line_fetch_memory: vector table, hand-written
// flush/reset/buffer sequences and randomized requests against a line model.
module tb_mips_line_fetch_memory;

  localparam int AW  = 32;
  localparam int MB  = 1024;
  localparam int LB  = 16;
  localparam int LAT = 4;
`ifdef INSMEM_LINEBUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT;
`endif

  logic          ClockPulse = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          Flush = 1'b0;
  logic          RespReady = 1'b0;
  logic [AW-1:0] InstructionAddress = '0;
  logic          ReqReady, RespValid, AddrError;
  logic [127:0]  OutputInsMemory;
  logic [AW-1:0] RespAddress;

  mips_line_fetch_memory #(.ADDR_WIDTH(AW), .MEM_BYTES(MB), .LINE_BYTES(LB), .LATENCY(LAT)) dut (
    .ClockPulse         (ClockPulse),
    .Reset              (Reset),
    .ReqValid           (ReqValid),
    .ReqReady           (ReqReady),
    .InstructionAddress (InstructionAddress),
    .Flush              (Flush),
    .RespValid          (RespValid),
    .RespReady          (RespReady),
    .OutputInsMemory    (OutputInsMemory),
    .RespAddress        (RespAddress),
    .AddrError          (AddrError)
  );

  always #5 ClockPulse = ~ClockPulse;

  int           n_pass = 0;
  int           n_total = 0;
  byte unsigned mem_model [MB];
  bit           mb_valid = 1'b0;
  logic [31:0]  mb_line = '0;

  typedef struct {
    logic [31:0]  addr;
    int           stall;
    logic [127:0] data;
    logic [31:0]  raddr;
    bit           err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge ClockPulse);
    #1;
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LB - 1);
  endfunction

  function automatic bit is_err(input logic [31:0] line);
    logic [63:0] end_addr;
    end_addr = {32'b0, line} + 64'(LB);
    return end_addr > 64'(MB);
  endfunction

  function automatic logic [127:0] model_data(input logic [31:0] line);
    logic [127:0] d;
    d = '0;
    if (!is_err(line))
      for (int k = 0; k < LB; k++) d[k*8 +: 8] = mem_model[line + k];
    return d;
  endfunction

  function automatic int model_lat(input logic [31:0] line);
    return (HIT_LAT != LAT && mb_valid && mb_line == line) ? HIT_LAT : LAT;
  endfunction

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!RespValid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic accept_req(input logic [31:0] a);
    int g;
    ReqValid = 1'b1;
    InstructionAddress = a;
    #1;
    g = 0;
    while (!ReqReady && g < 20) begin
      step();
      g++;
    end
    if (g == 20) chk("accept_timeout", ReqReady, 1);
    step();
    ReqValid = 1'b0;
  endtask

  task automatic run_fetch(input string name, input logic [31:0] a, input int stall,
                           input int exp_lat, input logic [127:0] exp_data,
                           input logic [31:0] exp_addr, input bit exp_err);
    int lat;
    RespReady = 1'b0;
    accept_req(a);
    wait_resp(lat);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " data"}, OutputInsMemory, exp_data);
    chk({name, " addr"}, RespAddress, exp_addr);
    chk({name, " err"}, AddrError, exp_err);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({name, " hold valid/ready"}, {RespValid, ReqReady}, 2'b10);
      chk({name, " hold data"}, OutputInsMemory, exp_data);
      chk({name, " hold addr/err"}, {RespAddress, AddrError}, {exp_addr, exp_err});
    end
    RespReady = 1'b1;
    #1;
    chk({name, " no accept on consume"}, ReqReady, 0);
    step();
    RespReady = 1'b0;
    chk({name, " after consume"}, {RespValid, ReqReady}, 2'b01);
    if (!exp_err) begin
      mb_valid = 1'b1;
      mb_line  = exp_addr;
    end
  endtask

  task automatic check_cleared(input string name);
    chk({name, " RespValid"}, RespValid, 0);
    chk({name, " data"}, OutputInsMemory, 0);
    chk({name, " addr/err"}, {RespAddress, AddrError}, 0);
  endtask

  task automatic no_resp_for(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (RespValid) seen = 1'b1;
    end
    chk({name, " no stale response"}, seen, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] a, line;

    for (int i = 0; i < MB; i++) mem_model[i] = 8'(i);
    vecs[0] = '{32'h24,       3, 128'h2F2E2D2C2B2A29282726252423222120, 32'h20,       1'b0};
    vecs[1] = '{32'h3F8,      0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 32'h3F0,      1'b0};
    vecs[2] = '{32'h400,      1, 128'h0,                                 32'h400,      1'b1};
    vecs[3] = '{32'h0,        0, 128'h0F0E0D0C0B0A09080706050403020100, 32'h0,        1'b0};
    vecs[4] = '{32'h105,      2, 128'h0F0E0D0C0B0A09080706050403020100, 32'h100,      1'b0};
    vecs[5] = '{32'hFFFFFFF3, 0, 128'h0,                                 32'hFFFFFFF0, 1'b1};

    // Reset state
    step();
    step();
    check_cleared("reset");
    Reset = 1'b0;
    #1;
    chk("ready after reset", ReqReady, 1);

    // Flush in IDLE blocks acceptance only
    Flush = 1'b1;
    ReqValid = 1'b1;
    InstructionAddress = 32'h40;
    #1;
    chk("flush idle ready", ReqReady, 0);
    step();
    Flush = 1'b0;
    ReqValid = 1'b0;
    #1;
    chk("flush idle ready back", ReqReady, 1);
    no_resp_for("flush idle", 6);

    foreach (vecs[i])
      run_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].stall, LAT,
                vecs[i].data, vecs[i].raddr, vecs[i].err);

    // Buffer fill, flush mid-WAIT (buffer must survive), then a same-line request
    run_fetch("fill 0x20", 32'h20, 0, model_lat(32'h20), model_data(32'h20), 32'h20, 1'b0);
    accept_req(32'h60);
    chk("flush wait valid", RespValid, 0);
    step();
    Flush = 1'b1;
    #1;
    chk("flush wait ready low", ReqReady, 0);
    step();
    chk("flush wait dropped", RespValid, 0);
    Flush = 1'b0;
    #1;
    chk("ready after flush", ReqReady, 1);
    no_resp_for("flush wait", 6);
    run_fetch("hit 0x2C", 32'h2C, 0, HIT_LAT,
              128'h2F2E2D2C2B2A29282726252423222120, 32'h20, 1'b0);

    // Flush beats RespReady in RESP: response dropped, buffer not updated
    accept_req(32'h80);
    wait_resp(lat);
    chk("flush resp latency", lat, LAT);
    Flush = 1'b1;
    RespReady = 1'b1;
    step();
    Flush = 1'b0;
    RespReady = 1'b0;
    #1;
    chk("flush resp dropped", {RespValid, ReqReady}, 2'b01);
    run_fetch("after drop 0x84", 32'h84, 0, LAT, model_data(32'h80), 32'h80, 1'b0);

    // Reset in WAIT
    accept_req(32'h24);
    step();
    Reset = 1'b1;
    step();
    check_cleared("reset wait");
    Reset = 1'b0;
    #1;
    chk("reset wait ready", ReqReady, 1);
    no_resp_for("reset wait", 8);

    // Reset in RESP
    accept_req(32'h3F8);
    wait_resp(lat);
    chk("reset resp reached", RespValid, 1);
    Reset = 1'b1;
    step();
    check_cleared("reset resp");
    Reset = 1'b0;
    no_resp_for("reset resp", 8);
    mb_valid = 1'b0;
    run_fetch("after reset 0x88", 32'h88, 0, LAT, model_data(32'h80), 32'h80, 1'b0);

    // Randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = mb_line + 32'($urandom_range(0, LB - 1));
        default: a = 32'($urandom_range(0, 'h47F));
      endcase
      line = line_of(a);
      run_fetch($sformatf("rand%0d", i), a, $urandom_range(0, 2), model_lat(line),
                model_data(line), line, is_err(line));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_line_fetch_memory.md
MIPS_LINE_FETCH_MEMORY -- requirements
Module: mips_line_fetch_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the byte address.
REQ-002 SHALL have parameter MEM_BYTES, default 1024: byte depth; multiple of LINE_BYTES.
REQ-003 SHALL have parameter LINE_BYTES, default 16: bytes per fetched line; power of two, at least 4.
REQ-004 SHALL have parameter LATENCY, default 4: cycles from request acceptance to RespValid on a miss; at least 2.
REQ-005 SHALL have port ClockPulse, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ReqValid, input, 1 bit: a fetch request is present.
REQ-008 SHALL have port ReqReady, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port InstructionAddress, input, ADDR_WIDTH bits: byte address of the request.
REQ-010 SHALL have port Flush, input, 1 bit: branch redirect that drops any in-flight fetch.
REQ-011 SHALL have port RespValid, output, 1 bit: OutputInsMemory holds a valid line.
REQ-012 SHALL have port RespReady, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port OutputInsMemory, output, LINE_BYTES*8 bits: the fetched line.
REQ-014 SHALL have port RespAddress, output, ADDR_WIDTH bits: line-aligned address of the response.
REQ-015 SHALL have port AddrError, output, 1 bit: the response line lies outside MEM_BYTES.

Function
REQ-016 SHALL use line address InstructionAddress[ADDR_WIDTH-1:log2(LINE_BYTES)] and ignore the low bits; RespAddress SHALL be that line address with zero low bits.
REQ-017 SHALL initialise byte i of the memory to i[7:0]; the memory is read-only.
REQ-018 SHALL assemble each line little-endian: the byte at the line base goes to OutputInsMemory[7:0], and base+LINE_BYTES-1 goes to the top byte.
REQ-019 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-020 SHALL drive ReqReady = (state==IDLE) && !Flush.
REQ-021 SHALL accept a request on a ReqValid&&ReqReady edge, latch the line address, and go IDLE->WAIT.
REQ-022 SHALL make the WAIT->RESP transition such that RespValid rises exactly LATENCY cycles after the acceptance edge.
REQ-023 SHALL hold RESP with stable RespValid, OutputInsMemory, RespAddress and AddrError until RespValid&&RespReady, then go to IDLE.
REQ-024 SHALL NOT accept a new request in the cycle a response is consumed; the next request is accepted in IDLE the following cycle.
REQ-025 SHALL, on Flush in WAIT or RESP, go to IDLE next edge with no response delivered; Flush in IDLE SHALL block acceptance only.
REQ-026 SHALL give Flush priority over RespReady when both are high in RESP, so the response is dropped.
REQ-027 SHALL, when the line base+LINE_BYTES exceeds MEM_BYTES, still respond after LATENCY cycles with AddrError=1 and OutputInsMemory=0.
REQ-028 SHALL hold AddrError=0 for every in-range response.

Reset
REQ-029 SHALL make Reset take precedence over all inputs, including mid-WAIT and mid-RESP, where the in-flight fetch is discarded.
REQ-030 SHALL set these values one edge after Reset: state IDLE, RespValid 0, OutputInsMemory 0, RespAddress 0, AddrError 0, wait counter 0, line buffer invalid.
REQ-031 SHALL drive ReqReady=1 in the first cycle after Reset deasserts, unless Flush is high.

Configuration
REQ-032 SHALL, with INSMEM_LINEBUF_EN defined, keep a one-entry buffer of the last delivered in-range line and its address.
REQ-033 SHALL, with INSMEM_LINEBUF_EN defined, send an accepted request that matches a valid buffer entry directly to RESP, with RespValid one cycle after acceptance.
REQ-034 SHALL, with INSMEM_LINEBUF_EN defined, leave the buffer intact on Flush and invalidate it only on Reset.
REQ-035 SHALL, without INSMEM_LINEBUF_EN, have no buffer, so every request takes LATENCY cycles.

Structure
REQ-036 SHALL place the FSM state enum, default parameter constants and the log2 line-offset function in package mips_insmem_pkg.
REQ-037 SHALL implement the WAIT countdown in sub-module mips_insmem_wait_counter, with load, clear and done signals, cleared by Reset and Flush.

Verification
REQ-038 SHALL cover: defaults; request 0x24 accepted at cycle 0 -> RespValid at cycle 4, RespAddress=0x20, OutputInsMemory=128'h2F2E2D2C2B2A29282726252423222120.
REQ-039 SHALL cover: RespReady low for 3 cycles in RESP -> outputs stable, and ReqReady=0 throughout.
REQ-040 SHALL cover: Flush at cycle 2 of WAIT -> no RespValid, and ReqReady=1 the cycle after Flush drops.
REQ-041 SHALL cover: request 0x3F8 with LINE_BYTES=16 -> line 0x3F0 is in range with top byte 0xFF; request 0x400 -> AddrError=1 and data 0.
REQ-042 SHALL cover: consumed line 0x20, then request 0x2C -> RespValid 1 cycle after acceptance with INSMEM_LINEBUF_EN, 4 cycles without.
REQ-043 SHALL cover: Reset asserted in WAIT and again in RESP -> all outputs 0 next edge, and no stale response afterwards.
